// File: rtl/sram_synaptic_arbiter_if.sv
// Handshake and SRAM bus bundle for sram_synaptic_arbiter; slave is the arbiter side,
// master is the requester/SRAM-model side.
interface sram_synaptic_arbiter_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 8,
  parameter int LANE_WIDTH   = 2
);
  logic                    rd_req;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_ready;
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data;

  logic                    upd_req;
  logic [ADDR_WIDTH-1:0]   upd_addr;
  logic [LANE_WIDTH-1:0]   upd_lane;
  logic [WEIGHT_WIDTH-1:0] upd_delta;
  logic                    upd_gnt;
  logic                    upd_done;

  logic                    sram_cs;
  logic                    sram_we;
  logic [ADDR_WIDTH-1:0]   sram_a;
  logic [DATA_WIDTH-1:0]   sram_d;
  logic [DATA_WIDTH-1:0]   sram_q;

  modport slave (
    input  rd_req, rd_addr, upd_req, upd_addr, upd_lane, upd_delta, sram_q,
    output rd_ready, rd_valid, rd_data, upd_gnt, upd_done,
           sram_cs, sram_we, sram_a, sram_d
  );

  modport master (
    output rd_req, rd_addr, upd_req, upd_addr, upd_lane, upd_delta, sram_q,
    input  rd_ready, rd_valid, rd_data, upd_gnt, upd_done,
           sram_cs, sram_we, sram_a, sram_d
  );
endinterface

// File: rtl/sram_synaptic_arbiter.sv
// Shares a single-port weight SRAM between inference reads (priority, 1/cycle, data 1 cycle after
// accept) and 3-cycle saturating lane RMW updates; optional perf counter under SYN_ARB_PERF_CNT_EN.
module sram_synaptic_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 8,
  parameter int LANE_WIDTH   = 2,
  parameter int MAX_STALL    = 8
) (
  input  logic CK,
  input  logic RST_N,
  sram_synaptic_arbiter_if.slave bus
`ifdef SYN_ARB_PERF_CNT_EN
  ,
  output logic [15:0] perf_conflicts
`endif
);

  localparam int LANES = DATA_WIDTH / WEIGHT_WIDTH;
  localparam int SW    = $clog2(MAX_STALL + 1);
  localparam int W     = WEIGHT_WIDTH;

  typedef enum logic [1:0] {IDLE, RMW_CALC, RMW_WR} state_t;

  state_t                  state, state_nxt;
  logic [SW-1:0]           stall_cnt;
  logic                    rd_valid_q;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [LANE_WIDTH-1:0]   cap_lane;
  logic [W-1:0]            cap_delta;
  logic [DATA_WIDTH-1:0]   new_word;

  logic                    force_upd, grant_rd, grant_upd;
  logic                    rd_ready, upd_gnt, upd_done;
  logic                    cs, we;
  logic [ADDR_WIDTH-1:0]   a;
  logic [DATA_WIDTH-1:0]   d;

  logic [W-1:0]            lane_old, lane_sat;
  logic [W:0]              lane_sum;
  logic [DATA_WIDTH-1:0]   merged;

  // Outputs are gated by RST_N so nothing reaches the SRAM while reset is asserted.
  always_comb begin
    state_nxt = state;
    force_upd = 1'b0;
    grant_rd  = 1'b0;
    grant_upd = 1'b0;
    rd_ready  = 1'b0;
    upd_gnt   = 1'b0;
    upd_done  = 1'b0;
    cs        = 1'b0;
    we        = 1'b0;
    a         = '0;
    d         = '0;
    if (RST_N) begin
      case (state)
        IDLE: begin
          force_upd = bus.upd_req && (stall_cnt == SW'(MAX_STALL));
          rd_ready  = !force_upd;
          if (force_upd)        grant_upd = 1'b1;
          else if (bus.rd_req)  grant_rd  = 1'b1;
          else if (bus.upd_req) grant_upd = 1'b1;
          if (grant_rd) begin
            cs = 1'b1;
            a  = bus.rd_addr;
          end
          if (grant_upd) begin
            cs        = 1'b1;
            a         = bus.upd_addr;
            upd_gnt   = 1'b1;
            state_nxt = RMW_CALC;
          end
        end
        RMW_CALC: state_nxt = RMW_WR;
        RMW_WR: begin
          cs        = 1'b1;
          we        = 1'b1;
          a         = cap_addr;
          d         = new_word;
          upd_done  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Lane extract, widened add, and clamp on signed overflow.
  always_comb begin
    lane_old = '0;
    for (int i = 0; i < LANES; i++)
      if (cap_lane == LANE_WIDTH'(i)) lane_old = bus.sram_q[i*W +: W];
    lane_sum = {lane_old[W-1], lane_old} + {cap_delta[W-1], cap_delta};
    if (lane_sum[W] != lane_sum[W-1])
      lane_sat = lane_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      lane_sat = lane_sum[W-1:0];
    merged = bus.sram_q;
    for (int i = 0; i < LANES; i++)
      if (cap_lane == LANE_WIDTH'(i)) merged[i*W +: W] = lane_sat;
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state      <= IDLE;
      stall_cnt  <= '0;
      rd_valid_q <= 1'b0;
      cap_addr   <= '0;
      cap_lane   <= '0;
      cap_delta  <= '0;
      new_word   <= '0;
    end else begin
      state      <= state_nxt;
      rd_valid_q <= grant_rd;
      if (grant_upd) begin
        cap_addr  <= bus.upd_addr;
        cap_lane  <= bus.upd_lane;
        cap_delta <= bus.upd_delta;
      end
      if (state == RMW_CALC) new_word <= merged;
      if (!bus.upd_req || grant_upd)
        stall_cnt <= '0;
      else if (grant_rd && stall_cnt != SW'(MAX_STALL))
        stall_cnt <= stall_cnt + SW'(1);
    end
  end

`ifdef SYN_ARB_PERF_CNT_EN
  always_ff @(posedge CK) begin
    if (!RST_N)
      perf_conflicts <= '0;
    else if (state == IDLE && bus.rd_req && bus.upd_req && perf_conflicts != 16'hFFFF)
      perf_conflicts <= perf_conflicts + 16'd1;
  end
`endif

  assign bus.rd_ready = rd_ready;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = bus.sram_q;
  assign bus.upd_gnt  = upd_gnt;
  assign bus.upd_done = upd_done;
  assign bus.sram_cs  = cs;
  assign bus.sram_we  = we;
  assign bus.sram_a   = a;
  assign bus.sram_d   = d;

endmodule

// File: tb/tb_sram_synaptic_arbiter.sv
// Directed bench for sram_synaptic_arbiter: SRAM model, scoreboard queues for read data and
// SRAM writes checked by a negedge monitor, plus inline timing checks.
module tb_sram_synaptic_arbiter;

  logic CK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CK = ~CK;

  sram_synaptic_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WEIGHT_WIDTH(8), .LANE_WIDTH(2)) bus();

`ifdef SYN_ARB_PERF_CNT_EN
  logic [15:0] perf_conflicts;
`endif

  sram_synaptic_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .WEIGHT_WIDTH(8), .LANE_WIDTH(2), .MAX_STALL(8)
  ) dut (
    .CK(CK),
    .RST_N(RST_N),
    .bus(bus)
`ifdef SYN_ARB_PERF_CNT_EN
    ,
    .perf_conflicts(perf_conflicts)
`endif
  );

  logic [31:0] mem [0:255];
  always @(posedge CK) begin
    if (bus.sram_cs) begin
      if (bus.sram_we) mem[bus.sram_a] <= bus.sram_d;
      else             bus.sram_q      <= mem[bus.sram_a];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] rd_q [$];
  logic [39:0] wr_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {bus.rd_ready, bus.rd_valid, bus.upd_gnt, bus.upd_done,
            bus.sram_cs, bus.sram_we, bus.sram_a, bus.sram_d};
  endfunction

  // Monitor: pops scoreboard entries whenever the DUT presents read data or an SRAM write.
  always @(negedge CK) begin
    if (bus.rd_valid) begin
      if (rd_q.size() == 0) check("unexpected_rd_valid", 64'(bus.rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("rd_data", 64'(bus.rd_data), 64'(rd_q.pop_front()));
    end
    if (bus.sram_cs && bus.sram_we) begin
      if (wr_q.size() == 0) check("unexpected_write", 64'({bus.sram_a, bus.sram_d}), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("sram_write", 64'({bus.sram_a, bus.sram_d}), 64'(wr_q.pop_front()));
    end
    if (bus.upd_done || (bus.sram_cs && bus.sram_we))
      check("done_with_write", 64'(bus.upd_done), 64'(bus.sram_cs && bus.sram_we));
  end

  always @(negedge CK)
    if (RST_N && bus.upd_gnt)
      assert (int'(bus.upd_lane) < 4) else $error("lane index out of range");

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic do_upd(input logic [7:0] addr, input logic [1:0] lane,
                        input logic [7:0] delta, input logic [31:0] exp_word);
    wr_q.push_back({addr, exp_word});
    bus.upd_req = 1'b1; bus.upd_addr = addr; bus.upd_lane = lane; bus.upd_delta = delta;
    @(negedge CK);
    check("upd_gnt_t", 64'(bus.upd_gnt), 64'd1);
    step();
    bus.upd_req = 1'b0;
    @(negedge CK);
    check("upd_done_t1", 64'({bus.upd_gnt, bus.upd_done, bus.rd_ready}), 64'd0);
    step();
    @(negedge CK);
    check("upd_done_t2", 64'(bus.upd_done), 64'd1);
    step();
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_word);
    rd_q.push_back(exp_word);
    bus.rd_req = 1'b1; bus.rd_addr = addr;
    step();
    bus.rd_req = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int grants;
    bit got;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'hA5A5_0000; mem[1] = 32'h5A5A_0001; mem[2] = 32'h1234_5678;
    mem[3] = 32'hDEAD_BEEF; mem[5] = 32'h1122_3344; mem[6] = 32'h1234_567E;
    mem[7] = 32'h8134_5678; mem[8] = 32'h0000_0000; mem[9] = 32'hCAFE_F00D;

    bus.rd_req = 1'b1; bus.rd_addr = 8'h3;
    bus.upd_req = 1'b1; bus.upd_addr = 8'h4; bus.upd_lane = 2'd0; bus.upd_delta = 8'h1;
    step(); step();
    @(negedge CK);
    check("reset_outputs", outs(), 64'd0);
    bus.rd_req = 1'b0; bus.upd_req = 1'b0;
    step();
    RST_N = 1'b1;
    @(negedge CK);
    check("idle_rd_ready", 64'({bus.rd_ready, bus.sram_cs, bus.rd_valid}), 64'b100);
`ifdef SYN_ARB_PERF_CNT_EN
    check("perf_after_reset", 64'(perf_conflicts), 64'd0);
`endif
    step();

    // Back-to-back reads
    for (int i = 0; i < 3; i++) begin
      bus.rd_req = 1'b1; bus.rd_addr = 8'(i);
      rd_q.push_back(mem[i]);
      step();
    end
    bus.rd_req = 1'b0;
    step(); step();

    // Single RMW then read-back
    do_upd(8'd5, 2'd1, 8'h10, 32'h1122_4344);
    do_read(8'd5, 32'h1122_4344);

    // Saturation, positive and negative
    do_upd(8'd6, 2'd0, 8'h05, 32'h1234_567F);
    do_upd(8'd7, 2'd3, 8'hFC, 32'h8034_5678);
    do_read(8'd6, 32'h1234_567F);
    do_read(8'd7, 32'h8034_5678);

    // Starvation: exactly 8 read grants then forced update
    for (int i = 0; i < 8; i++) rd_q.push_back(32'hDEAD_BEEF);
    wr_q.push_back({8'd8, 32'h0001_0000});
    bus.rd_req = 1'b1; bus.rd_addr = 8'd3;
    bus.upd_req = 1'b1; bus.upd_addr = 8'd8; bus.upd_lane = 2'd2; bus.upd_delta = 8'h01;
    grants = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CK);
      if (bus.upd_gnt) begin
        got = 1'b1;
        check("forced_rd_ready", 64'(bus.rd_ready), 64'd0);
      end else begin
        if (bus.rd_ready) grants++;
        step();
      end
    end
    check("forced_grant_seen", 64'(got), 64'd1);
    check("reads_before_force", 64'(grants), 64'd8);
    step();
    bus.rd_req = 1'b0; bus.upd_req = 1'b0;
    step(); step(); step();

    // One more IDLE conflict: read wins with stall_cnt cleared
    rd_q.push_back(32'hDEAD_BEEF);
    bus.rd_req = 1'b1; bus.rd_addr = 8'd3; bus.upd_req = 1'b1;
    @(negedge CK);
    check("conflict_read_wins", 64'({bus.rd_ready, bus.upd_gnt}), 64'b10);
    step();
    bus.rd_req = 1'b0; bus.upd_req = 1'b0;
    step();
`ifdef SYN_ARB_PERF_CNT_EN
    check("perf_conflicts", 64'(perf_conflicts), 64'd10);
`endif

    // Reset during RMW_CALC aborts the write
    bus.upd_req = 1'b1; bus.upd_addr = 8'd9; bus.upd_lane = 2'd0; bus.upd_delta = 8'h01;
    @(negedge CK);
    check("abort_upd_gnt", 64'(bus.upd_gnt), 64'd1);
    step();
    RST_N = 1'b0; bus.upd_req = 1'b0;
    @(negedge CK);
    check("abort_outputs_zero", outs(), 64'd0);
    step();
    @(negedge CK);
    check("abort_outputs_zero2", outs(), 64'd0);
    step();
    RST_N = 1'b1;
    @(negedge CK);
    check("abort_back_idle", 64'({bus.rd_ready, bus.upd_done, bus.sram_we}), 64'b100);
`ifdef SYN_ARB_PERF_CNT_EN
    check("perf_cleared", 64'(perf_conflicts), 64'd0);
`endif
    step();
    do_read(8'd9, 32'hCAFE_F00D);
    step(); step();

    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
